// File: rtl/pac_move_ctrl.sv
// Pac-Man movement initiator: owns tile-aligned position/heading, probes the
// collision checker once per move slot and commits, retries or stops.
module pac_move_ctrl #(
  parameter int unsigned TILE    = 32,
  parameter int unsigned CHK_LAT = 2,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 608,
  parameter int unsigned Y_MIN   = 0,
  parameter int unsigned Y_MAX   = 448,
  parameter int unsigned START_X = 288,
  parameter int unsigned START_Y = 352
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       dir_req_valid,
  input  logic [1:0] dir_req,
  output logic [9:0] probe_x,
  output logic [8:0] probe_y,
  output logic [1:0] probe_dir,
  input  logic       can_move,
  output logic [9:0] pac_x,
  output logic [8:0] pac_y,
  output logic [1:0] pac_dir,
  output logic       moving,
  output logic       busy,
  output logic       step_done
);

  typedef enum logic [1:0] {IDLE, PROBE_A, PROBE_B, DECIDE} state_t;

  localparam logic [1:0]  D_UP    = 2'b00;
  localparam logic [1:0]  D_DOWN  = 2'b01;
  localparam logic [1:0]  D_LEFT  = 2'b10;
  localparam logic [1:0]  D_RIGHT = 2'b11;

  localparam logic [10:0] X_LO_W  = 11'(X_MIN + TILE);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] TILE_XW = 11'(TILE);
  localparam logic [9:0]  Y_LO_W  = 10'(Y_MIN + TILE);
  localparam logic [9:0]  Y_MAX_W = 10'(Y_MAX);
  localparam logic [9:0]  TILE_YW = 10'(TILE);

  state_t     state, state_n;
  logic [3:0] cnt;
  logic       req_pending;
  logic [1:0] req_dir;
  logic       probe_req;   // current probe used the buffered request
  logic       from_a;      // decision follows the first probe of this slot
  logic       cm_q;        // can_move sampled at end of probe wait

  logic       vblock, ok, retry;
  logic [10:0] sum_x;
  logic [9:0]  sum_y;
  logic [9:0]  nx;
  logic [8:0]  ny;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state selection
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:             if (move_tick) state_n = PROBE_A;
      PROBE_A, PROBE_B: if (cnt == 4'd1) state_n = DECIDE;
      DECIDE:           state_n = retry ? PROBE_B : IDLE;
      default:          state_n = IDLE;
    endcase
  end

  // Decision and target-position computation
  always_comb begin
    sum_x  = {1'b0, pac_x} + TILE_XW;
    sum_y  = {1'b0, pac_y} + TILE_YW;
    vblock = ((probe_dir == D_UP)   && ({1'b0, pac_y} < Y_LO_W)) ||
             ((probe_dir == D_DOWN) && (sum_y > Y_MAX_W));
    ok     = cm_q && !vblock;
    retry  = !ok && from_a && probe_req && (probe_dir != pac_dir);
    nx     = pac_x;
    ny     = pac_y;
    unique case (probe_dir)
      D_UP:    ny = pac_y - 9'(TILE);
      D_DOWN:  ny = sum_y[8:0];
      D_LEFT:  nx = ({1'b0, pac_x} < X_LO_W) ? 10'(X_MAX) : pac_x - 10'(TILE);
      D_RIGHT: nx = (sum_x > X_MAX_W) ? 10'(X_MIN) : sum_x[9:0];
      default: ;
    endcase
  end

  // Registered datapath: request buffer, probe outputs, position and status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pac_x       <= 10'(START_X);
      pac_y       <= 9'(START_Y);
      pac_dir     <= D_LEFT;
      probe_x     <= 10'(START_X);
      probe_y     <= 9'(START_Y);
      probe_dir   <= D_LEFT;
      moving      <= 1'b0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      req_pending <= 1'b0;
      req_dir     <= '0;
      probe_req   <= 1'b0;
      from_a      <= 1'b0;
      cm_q        <= 1'b0;
      cnt         <= '0;
    end else begin
      step_done <= 1'b0;
      busy      <= (state_n != IDLE);
      if (dir_req_valid) begin
        req_dir     <= dir_req;
        req_pending <= 1'b1;
      end
      unique case (state)
        IDLE: if (move_tick) begin
          probe_x   <= pac_x;
          probe_y   <= pac_y;
          probe_dir <= req_pending ? req_dir : pac_dir;
          probe_req <= req_pending;
          cnt       <= 4'(CHK_LAT);
        end
        PROBE_A, PROBE_B: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            cm_q   <= can_move;
            from_a <= (state == PROBE_A);
          end
        end
        DECIDE: begin
          if (ok) begin
            pac_x     <= nx;
            pac_y     <= ny;
            pac_dir   <= probe_dir;
            moving    <= 1'b1;
            step_done <= 1'b1;
            // a request landing in this same cycle keeps the buffer pending
            if (probe_req && !dir_req_valid) req_pending <= 1'b0;
          end else if (retry) begin
            probe_dir <= pac_dir;
            probe_req <= 1'b0;
            cnt       <= 4'(CHK_LAT);
          end else begin
            moving    <= 1'b0;
            step_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Directed bench for pac_move_ctrl with a registered collision-checker model
// and a scoreboard of expected move results.
module tb_pac_move_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_tick;
  logic       dir_req_valid;
  logic [1:0] dir_req;
  logic [9:0] probe_x;
  logic [8:0] probe_y;
  logic [1:0] probe_dir;
  logic       can_move;
  logic [9:0] pac_x;
  logic [8:0] pac_y;
  logic [1:0] pac_dir;
  logic       moving;
  logic       busy;
  logic       step_done;

  pac_move_ctrl #(.TILE(32), .CHK_LAT(2)) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick),
    .dir_req_valid(dir_req_valid), .dir_req(dir_req),
    .probe_x(probe_x), .probe_y(probe_y), .probe_dir(probe_dir),
    .can_move(can_move), .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir),
    .moving(moving), .busy(busy), .step_done(step_done)
  );

  always #5 clk = ~clk;

  // Checker model: one register stage on the probe, then a free-direction map.
  logic [3:0] free_mask;
  logic [1:0] chk_dir;
  always @(posedge clk) chk_dir <= probe_dir;
  assign can_move = free_mask[chk_dir];

  typedef struct { int x; int y; int dir; int mv; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int m_x, m_y, m_dir, m_pend, m_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 288; m_y = 352; m_dir = 2; m_pend = 0; m_req = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pac_x"}, pac_x, 288);
    chk({tag, "_pac_y"}, pac_y, 352);
    chk({tag, "_pac_dir"}, pac_dir, 2);
    chk({tag, "_probe_x"}, probe_x, 288);
    chk({tag, "_probe_y"}, probe_y, 352);
    chk({tag, "_probe_dir"}, probe_dir, 2);
    chk({tag, "_moving"}, moving, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_step_done"}, step_done, 0);
  endtask

  function automatic bit dir_free(int d);
    if (!free_mask[d]) return 0;
    if (d == 0 && m_y < 32) return 0;
    if (d == 1 && m_y + 32 > 448) return 0;
    return 1;
  endfunction

  task automatic step_model(int d);
    case (d)
      0: m_y = m_y - 32;
      1: m_y = m_y + 32;
      2: m_x = (m_x < 32) ? 608 : m_x - 32;
      default: m_x = (m_x + 32 > 608) ? 0 : m_x + 32;
    endcase
    m_dir = d;
  endtask

  task automatic predict(output exp_t e, output int cand, output int lat);
    int mv;
    cand = m_pend ? m_req : m_dir;
    lat  = 4;
    mv   = 0;
    if (dir_free(cand)) begin
      step_model(cand);
      m_pend = 0;
      mv = 1;
    end else if (m_pend && cand != m_dir) begin
      lat = 7;
      if (dir_free(m_dir)) begin
        step_model(m_dir);
        mv = 1;
      end
    end
    e = '{m_x, m_y, m_dir, mv};
  endtask

  task automatic send_req(input logic [1:0] d);
    @(negedge clk);
    dir_req_valid = 1'b1;
    dir_req = d;
    @(negedge clk);
    dir_req_valid = 1'b0;
    m_pend = 1;
    m_req = d;
  endtask

  // One move slot; optional extra tick, mid-move request and reset at given cycles.
  task automatic do_move(input int xtick_at, input int req_at, input int rst_at,
                         input logic [1:0] req_v);
    exp_t e, g;
    int cand, lat, pulses, first;
    pulses = 0; first = 0; lat = 0;
    if (rst_at == 0) begin
      predict(e, cand, lat);
      sb.push_back(e);
    end else begin
      cand = m_pend ? m_req : m_dir;
    end
    @(negedge clk);
    move_tick = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      move_tick     = (c == xtick_at);
      dir_req_valid = (c == req_at);
      dir_req       = req_v;
      if (c == 1) begin
        chk("probe_x", probe_x, m_x_before(e, cand, rst_at));
        chk("probe_dir", probe_dir, cand);
        chk("busy_in_probe", busy, 1);
      end
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        chk_reset("async_rst");
        model_reset();
      end
      if (step_done === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
        if (sb.size() > 0) begin
          g = sb.pop_front();
          chk("pac_x", pac_x, g.x);
          chk("pac_y", pac_y, g.y);
          chk("pac_dir", pac_dir, g.dir);
          chk("moving", moving, g.mv);
        end
      end
    end
    move_tick = 1'b0;
    dir_req_valid = 1'b0;
    if (rst_at != 0) rst = 1'b1;
    chk("step_pulses", pulses, (rst_at != 0) ? 0 : 1);
    if (rst_at == 0) chk("step_latency", first, lat);
    chk("busy_after", busy, 0);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
    if (req_at != 0) begin
      m_pend = 1;
      m_req = req_v;
    end
  endtask

  // Probe x at slot start is the pre-move position; recover it from the
  // prediction only when a step was taken horizontally.
  function automatic int m_x_before(exp_t e, int cand, int rst_at);
    if (rst_at != 0 || e.mv == 0 || (e.dir != 2 && e.dir != 3)) return m_x;
    if (e.dir == 2) return (e.x == 608) ? 0 : e.x + 32;
    return (e.x == 0) ? 608 : e.x - 32;
  endfunction

  initial begin
    rst = 1'b0;
    move_tick = 1'b0;
    dir_req_valid = 1'b0;
    dir_req = 2'b00;
    free_mask = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;

    // plain move left from start
    do_move(0, 0, 0, 2'b00);

    // request up blocked, fallback left; then up free clears the buffer
    send_req(2'b00);
    free_mask = 4'b1110;
    do_move(0, 0, 0, 2'b00);
    chk("req_pending_kept", dut.req_pending, m_pend);
    free_mask = 4'hF;
    do_move(0, 0, 0, 2'b00);
    chk("req_pending_clr", dut.req_pending, m_pend);

    // horizontal tunnel wrap both ways
    send_req(2'b10);
    repeat (8) do_move(0, 0, 0, 2'b00);
    send_req(2'b11);
    do_move(0, 0, 0, 2'b00);

    // climb to the top edge, then vertical bound blocks
    send_req(2'b00);
    repeat (10) do_move(0, 0, 0, 2'b00);
    send_req(2'b11);
    do_move(0, 0, 0, 2'b00);
    send_req(2'b00);
    do_move(0, 0, 0, 2'b00);
    send_req(2'b00);
    free_mask = 4'b0001;
    do_move(0, 0, 0, 2'b00);

    // extra tick while busy; request in the clearing DECIDE cycle survives
    free_mask = 4'hF;
    send_req(2'b01);
    do_move(2, 3, 0, 2'b10);
    chk("req_pending_race", dut.req_pending, m_pend);
    do_move(0, 0, 0, 2'b00);

    // reset during the retry probe
    send_req(2'b00);
    free_mask = 4'b0100;
    do_move(0, 0, 5, 2'b00);
    free_mask = 4'hF;
    do_move(0, 0, 0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
